// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command front end.
package alu_pkg;

    localparam int ALU_DW  = 4;
    localparam int ALU_OPW = 3;

    typedef enum logic [ALU_OPW-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_e;

    // One buffered response: result, the opcode that produced it, illegal-op flag.
    typedef struct packed {
        logic [ALU_DW-1:0]  result;
        logic [ALU_OPW-1:0] op;
        logic               err;
    } alu_rsp_t;

    // Legal opcodes are OP_ADD through OP_XOR; 101-111 are illegal.
    function automatic logic is_legal_op(input logic [ALU_OPW-1:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO. Pointers carry one extra bit so that
// full (MSBs differ, rest equal) and empty (all equal) are distinct.
// The head output reads as zero whenever the FIFO is empty.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers and storage; push and pop in one cycle are both honoured.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // State registers; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command front end for the combinational ALU: registers an accepted
// command onto the ALU inputs, captures the result one cycle later and
// queues {result, op, err} for the consumer.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid, once raised, holds its payload until the transfer;
// ready may depend on internal state only, never on the same-cycle valid.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DW         = 4,
    parameter int OPW        = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    input  logic [OPW-1:0] cmd_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_result,
    output logic [OPW-1:0] rsp_op,
    output logic           rsp_err,
    output logic [7:0]     op_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = DW + OPW + 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           err_q, err_d;
    logic [7:0]     op_count_q, op_count_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic [RW-1:0]  fifo_din;
    logic [RW-1:0]  fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;

    // Space check uses registered occupancy only, so a same-cycle pop never
    // opens the door early.
    logic           fifo_has_space;
    assign fifo_has_space = (fifo_count < DEPTH_CNT);

    // Next-state, ALU input load and result capture.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        err_d      = err_q;
        op_count_d = op_count_q;
        cmd_ready  = 1'b0;
        fifo_push  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = fifo_has_space;
                if (cmd_valid && fifo_has_space) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    err_d    = !is_legal_op(cmd_op);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Space was reserved at accept; the full guard is belt and braces.
                fifo_push  = !fifo_full;
                op_count_d = op_count_q + 8'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, ALU input and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    assign fifo_din = {alu_result, alu_op_q, err_q};
    assign fifo_pop = rsp_valid && rsp_ready;

    alu_rsp_fifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign op_count   = op_count_q;
    assign rsp_valid  = !fifo_empty;
    assign rsp_result = fifo_dout[RW-1 -: DW];
    assign rsp_op     = fifo_dout[OPW:1];
    assign rsp_err    = fifo_dout[0];

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU attached.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_count = 0;
    logic [7:0] exp_q[$];

    alu_cmd_driver #(.DW(4), .OPW(3), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The combinational ALU the block drives.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = 4'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response transfer is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got %0h with empty expected queue", {rsp_result, rsp_op, rsp_err});
            end else begin
                check("rsp_entry", {24'h0, rsp_result, rsp_op, rsp_err}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_op    = 3'b000;
        exp_q.delete();
        exp_count = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offers one command and returns #1 after the edge that accepted it.
    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                            output int acc_cyc);
        int budget;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        budget    = 0;
        while (!cmd_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", budget);
            cmd_valid = 1'b0;
            acc_cyc   = -1;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc   = cyc;
            cmd_valid = 1'b0;
            exp_count++;
        end
    endtask

    task automatic drain();
        int budget = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       err;
    } vec_t;

    vec_t vecs[8];
    vec_t bp[6];

    initial begin
        int acc;
        int prev_acc;
        logic stay_low;
        logic seen_valid;

        vecs[0] = '{4'h3, 4'h5, 3'b001, 4'hE, 1'b0};
        vecs[1] = '{4'hC, 4'hA, 3'b010, 4'h8, 1'b0};
        vecs[2] = '{4'hC, 4'h3, 3'b011, 4'hF, 1'b0};
        vecs[3] = '{4'hF, 4'h5, 3'b100, 4'hA, 1'b0};
        vecs[4] = '{4'h7, 4'h2, 3'b110, 4'h0, 1'b1};
        vecs[5] = '{4'h9, 4'h8, 3'b000, 4'h1, 1'b0};
        vecs[6] = '{4'h0, 4'h1, 3'b001, 4'hF, 1'b0};
        vecs[7] = '{4'h5, 4'h5, 3'b111, 4'h0, 1'b1};

        bp[0] = '{4'h1, 4'h1, 3'b000, 4'h2, 1'b0};
        bp[1] = '{4'h2, 4'h2, 3'b000, 4'h4, 1'b0};
        bp[2] = '{4'h9, 4'h2, 3'b001, 4'h7, 1'b0};
        bp[3] = '{4'h6, 4'h3, 3'b100, 4'h5, 1'b0};
        bp[4] = '{4'hF, 4'h6, 3'b010, 4'h6, 1'b0};
        bp[5] = '{4'h8, 4'h1, 3'b011, 4'h9, 1'b0};

        // Reset values.
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_op    = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_a", alu_a, 4'h0);
        check("rst_alu_b", alu_b, 4'h0);
        check("rst_alu_op", alu_op, 3'b000);
        check("rst_op_count", op_count, 8'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_fields", {rsp_result, rsp_op, rsp_err}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // First command: F + 1 wraps to 0; response one edge after the accept edge.
        rsp_ready = 1'b1;
        exp_q.push_back({4'h0, 3'b000, 1'b0});
        send_cmd(4'hF, 4'h1, 3'b000, acc);
        check("first_alu_inputs", {alu_a, alu_b, alu_op}, {4'hF, 4'h1, 3'b000});
        check("first_busy", cmd_ready, 1'b0);
        check("first_no_rsp_yet", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        check("first_rsp_valid", rsp_valid, 1'b1);
        check("first_rsp_fields", {rsp_result, rsp_op, rsp_err}, {4'h0, 3'b000, 1'b0});
        check("first_op_count", op_count, 8'd1);
        drain();

        // Streamed vectors: one accept every two cycles, results in order.
        prev_acc = -1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].res, vecs[i].op, vecs[i].err});
            send_cmd(vecs[i].a, vecs[i].b, vecs[i].op, acc);
            check("vec_alu_op", alu_op, vecs[i].op);
            if (i > 0) check("vec_accept_gap", acc - prev_acc, 2);
            prev_acc = acc;
        end
        drain();
        check("vec_op_count", op_count, exp_count);

        // Back-pressure: four fit, the fifth waits until a pop registers.
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back({bp[i].res, bp[i].op, bp[i].err});
        for (int i = 0; i < 4; i++) send_cmd(bp[i].a, bp[i].b, bp[i].op, acc);
        cmd_a     = bp[4].a;
        cmd_b     = bp[4].b;
        cmd_op    = bp[4].op;
        cmd_valid = 1'b1;
        stay_low  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (cmd_ready) stay_low = 1'b0;
        end
        check("full_ready_low", stay_low, 1'b1);
        check("full_cmd_ignored", {alu_a, alu_b, alu_op}, {bp[3].a, bp[3].b, bp[3].op});
        check("full_head", {rsp_valid, rsp_result, rsp_op, rsp_err}, {1'b1, bp[0].res, bp[0].op, bp[0].err});
        check("full_op_count", op_count, exp_count);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_pop", cmd_ready, 1'b1);
        send_cmd(bp[4].a, bp[4].b, bp[4].op, acc);
        send_cmd(bp[5].a, bp[5].b, bp[5].op, acc);
        drain();
        @(posedge clk);
        #1;
        check("bp_op_count", op_count, exp_count);

        // Counter wrap after 256 operations from reset.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            exp_q.push_back({4'hF, 3'b000, 1'b0});
            send_cmd(iv[3:0], ~iv[3:0], 3'b000, acc);
        end
        @(posedge clk);
        #1;
        check("count_255", op_count, 8'd255);
        exp_q.push_back({4'hF, 3'b000, 1'b0});
        send_cmd(4'h7, 4'h8, 3'b000, acc);
        @(posedge clk);
        #1;
        check("count_wrap", op_count, 8'd0);
        drain();

        // Push and pop on the same edge at occupancy 2.
        rsp_ready = 1'b0;
        exp_q.push_back({4'h3, 3'b000, 1'b0});
        exp_q.push_back({4'h4, 3'b001, 1'b0});
        exp_q.push_back({4'h1, 3'b011, 1'b0});
        send_cmd(4'h1, 4'h2, 3'b000, acc);
        send_cmd(4'h6, 4'h2, 3'b001, acc);
        @(posedge clk);
        #1;
        check("pp_occ_before", dut.u_fifo.count, 3'd2);
        send_cmd(4'h1, 4'h0, 3'b011, acc);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("pp_occ_after", dut.u_fifo.count, 3'd2);
        check("pp_op_count", op_count, 8'd3);
        check("pp_head", {rsp_result, rsp_op, rsp_err}, {4'h4, 3'b001, 1'b0});
        drain();

        // Reset during EXEC with two entries buffered.
        rsp_ready = 1'b0;
        send_cmd(4'h2, 4'h2, 3'b000, acc);
        send_cmd(4'h5, 4'h1, 3'b100, acc);
        send_cmd(4'hA, 4'h6, 3'b001, acc);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        cmd_valid = 1'b0;
        check("mid_rst_rsp", {rsp_valid, rsp_result, rsp_op, rsp_err}, 9'h000);
        check("mid_rst_alu", {alu_a, alu_b, alu_op}, 11'h000);
        check("mid_rst_op_count", op_count, 8'd0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_count = 0;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        rsp_ready  = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen_valid = 1'b1;
        end
        check("post_rst_no_stale", seen_valid, 1'b0);
        exp_q.push_back({4'h5, 3'b000, 1'b0});
        send_cmd(4'h2, 4'h3, 3'b000, acc);
        @(posedge clk);
        #1;
        check("post_rst_op_count", op_count, 8'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Initiator-side front end for the 4-bit combinational ALU. It accepts operation commands over a valid/ready interface and registers the operands and opcode onto the ALU input bus. It samples the ALU result and returns it, tagged with its opcode and an illegal-op flag, through a buffered valid/ready response interface. It sits between the control/test sequencer and the ALU and turns the bare combinational datapath into a flow-controlled service.

## Interface
- `DW`, default 4: operand/result width; must match the ALU.
- `OPW`, default 3: opcode width.
- `FIFO_DEPTH`, default 4: response buffer entries; power of two, ≥2.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command this cycle.
- `cmd_a`, in, DW: operand A.
- `cmd_b`, in, DW: operand B.
- `cmd_op`, in, OPW: opcode.
- `alu_a`, out, DW: registered operand A to ALU.
- `alu_b`, out, DW: registered operand B to ALU.
- `alu_op`, out, OPW: registered opcode to ALU.
- `alu_result`, in, DW: combinational ALU result.
- `rsp_valid`, out, 1: FIFO head valid.
- `rsp_ready`, in, 1: consumer accepts head.
- `rsp_result`, out, DW: captured result.
- `rsp_op`, out, OPW: opcode that produced it.
- `rsp_err`, out, 1: opcode was outside 000–100.
- `op_count`, out, 8: completed-operation counter, wraps 255→0.

## Operation
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR. Codes 101–111 are illegal.
- All arithmetic is modulo 2^DW. There is no carry or borrow output.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - `cmd_ready` = 1 iff the FIFO has at least one free entry.
  - On `cmd_valid && cmd_ready`: load `alu_a`/`alu_b`/`alu_op` from `cmd_*`, latch err = (`cmd_op` > 3'b100), go to EXEC.
- EXEC:
  - `cmd_ready` = 0.
  - At the end of the cycle, push {`alu_result`, `alu_op`, err} into the FIFO, increment `op_count`, return to IDLE.
  - The push cannot overflow, because space was checked at accept.
- Illegal opcodes are still driven to the ALU. The captured result is whatever the ALU returns (0000 by the ALU's definition), with `rsp_err` = 1.
- `alu_a`/`alu_b`/`alu_op` hold their last values between commands.
- Response side: `rsp_*` present the FIFO head. An entry pops on `rsp_valid && rsp_ready`.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- A pop in the same cycle as an IDLE accept does not affect that cycle's `cmd_ready`. It is evaluated on registered occupancy only.
- `cmd_*` are ignored when `cmd_ready` = 0.

## Timing
- Reset values:
  - FSM = IDLE.
  - `alu_a`/`alu_b`/`alu_op` = 0.
  - `op_count` = 0.
  - FIFO empty: `rsp_valid` = 0, `rsp_result`/`rsp_op`/`rsp_err` = 0.
  - `cmd_ready` = 1 after reset release.
- Command accepted at edge N:
  - ALU inputs are valid during cycle N+1.
  - Result is pushed at edge N+1.
  - `rsp_valid` is high in cycle N+2 if the FIFO was empty.
  - Accept-to-response latency is 2 cycles.
- Throughput is one command per 2 cycles, with back-to-back accepts at edges N and N+2.
- FIFO full (occupancy = `FIFO_DEPTH`): `cmd_ready` = 0 until a pop registers.
- FIFO empty: `rsp_valid` = 0; `rsp_ready` is don't-care.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.
- Reset asserted mid-EXEC: the in-flight operation is discarded, the FIFO is flushed, and `op_count` is not incremented.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum (`OP_ADD`…`OP_XOR`).
  - `ALU_DW` = 4, `ALU_OPW` = 3.
  - Response struct {result, op, err}.
  - `is_legal_op()` function.
- The ALU itself also imports `alu_pkg`.
- Sub-module `alu_rsp_fifo`: parameterised synchronous FIFO with async active-low reset and push/pop/full/empty/count ports.
- FSM, ALU input registers and `op_count` live in the top level.

## Test plan
- Reset, then issue `cmd_a`=F, `cmd_b`=1, `cmd_op`=000 with `rsp_ready`=1 -> `rsp_valid` 2 cycles after accept, `rsp_result`=0, `rsp_op`=000, `rsp_err`=0, `op_count`=1.
- Stream SUB 3−5, AND C&A, OR C|3, XOR F^5 -> results E, 8, F, A in order, at one accept every 2 cycles.
- `cmd_op`=110, a=7, b=2 -> `alu_op`=110 driven, `rsp_result`=0, `rsp_err`=1, `op_count` increments.
- Hold `rsp_ready`=0 and offer 6 commands -> 4 accepted, then `cmd_ready` stays 0. Raise `rsp_ready` -> 4 responses drain in order, and `cmd_ready` returns high the cycle after the first pop.
- Issue 256 ADDs -> `op_count` wraps to 0. Simultaneous push/pop at occupancy 2 keeps occupancy 2.
- Assert `rst_n`=0 during EXEC with 2 entries buffered -> all outputs take reset values immediately. After release, `cmd_ready`=1 and no stale responses appear.
